// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
//
// Bundles every non-clock signal of the writeback stage: the execute-side
// valid/ready handshake, the memory read-data return, the register file write
// port, the pending-load export used for load-use stalls, and the sticky error
// flags.
//
// Modports:
//   slave  - the writeback stage itself (consumes ex_*/mem_*/err_clr,
//            drives ex_ready, the write port, pend_* and err_*)
//   master - the surrounding pipeline/memory (the reverse directions)
//
// Optional: LOAD_TIMEOUT_EN adds the sticky err_timeout flag.
// -----------------------------------------------------------------------------
interface writeback_stage_if #(
  parameter int XLEN = 32
);
  // Execute -> writeback handshake
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result;
  logic            ex_is_load;
  logic [2:0]      ex_funct3;
  logic [1:0]      ex_addr_lo;
  // Memory read data return
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  // Register file write port
  logic            w_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] rdv;
  // Pending load (for decode hazard detection)
  logic            pend_valid;
  logic [4:0]      pend_rd;
  // Sticky error flags
  logic            err_clr;
  logic            err_unexp;
  logic            err_misalign;
  logic            err_funct3;
`ifdef LOAD_TIMEOUT_EN
  logic            err_timeout;
`endif

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
    input  mem_rvalid, mem_rdata, err_clr,
    output ex_ready, w_en, rd, rdv, pend_valid, pend_rd,
`ifdef LOAD_TIMEOUT_EN
    output err_timeout,
`endif
    output err_unexp, err_misalign, err_funct3
  );

  modport master (
    output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
    output mem_rvalid, mem_rdata, err_clr,
    input  ex_ready, w_en, rd, rdv, pend_valid, pend_rd,
`ifdef LOAD_TIMEOUT_EN
    input  err_timeout,
`endif
    input  err_unexp, err_misalign, err_funct3
  );
endinterface

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final stage of the RV32I pipeline; produces the register file write port.
// ALU results are registered and written one cycle after acceptance. Loads
// park in WAIT_MEM until memory returns the read word, which is then aligned
// and sign/zero-extended before being written. While a load is outstanding
// the destination is exported on pend_valid/pend_rd for load-use stalls.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   wb     - writeback_stage_if.slave (handshake, memory return, write port,
//            pending-load export, sticky error flags)
//
// Parameters:
//   XLEN           - datapath width (only 32 supported)
//   TIMEOUT_CYCLES - WAIT_MEM cycle limit (used only with LOAD_TIMEOUT_EN)
//
// Optional feature: define LOAD_TIMEOUT_EN to abort loads that receive no
// mem_rvalid within TIMEOUT_CYCLES cycles and raise the sticky err_timeout.
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst_n,
  writeback_stage_if.slave wb
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_t          r_state;
  state_t          w_next_state;

  // Captured load attributes
  logic [4:0]      r_ld_rd;
  logic [2:0]      r_ld_funct3;
  logic [1:0]      r_ld_addr_lo;

  // Registered write port
  logic            r_w_en;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rdv;

  // Sticky errors
  logic            r_err_unexp;
  logic            r_err_misalign;
  logic            r_err_funct3;

  logic            w_accept;
  logic            w_accept_load;
  logic            w_ld_done;
  logic            w_tmo_hit;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ld_value;
  logic            w_bad_f3;
  logic            w_misalign;
  logic            w_wr_update;
  logic            w_wen_nxt;
  logic [4:0]      w_rd_nxt;
  logic [XLEN-1:0] w_rdv_nxt;

  assign w_accept      = wb.ex_valid && (r_state == IDLE);
  assign w_accept_load = w_accept && wb.ex_is_load;
  assign w_ld_done     = (r_state == WAIT_MEM) && wb.mem_rvalid;

`ifdef LOAD_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err_timeout;

  // The hit fires on the edge where the count would reach TIMEOUT_CYCLES;
  // a mem_rvalid on that same edge takes priority and completes the load.
  assign w_tmo_hit = (r_state == WAIT_MEM) && !wb.mem_rvalid &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_accept_load) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == WAIT_MEM) && !wb.mem_rvalid) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      r_err_timeout <= w_tmo_hit || (r_err_timeout && !wb.err_clr);
    end
  end

  assign wb.err_timeout = r_err_timeout;
`else
  // Without the timeout feature WAIT_MEM waits indefinitely.
  logic w_unused_timeout_param;
  assign w_unused_timeout_param = (TIMEOUT_CYCLES > 0);
  assign w_tmo_hit              = 1'b0;
`endif

  // Load data extraction from the captured byte offset and width.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    w_byte     = wb.mem_rdata[7:0];
    w_half     = r_ld_addr_lo[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
    w_ld_value = '0;
    w_bad_f3   = 1'b0;
    w_misalign = 1'b0;

    case (r_ld_addr_lo)
      2'd1:    w_byte = wb.mem_rdata[15:8];
      2'd2:    w_byte = wb.mem_rdata[23:16];
      2'd3:    w_byte = wb.mem_rdata[31:24];
      default: w_byte = wb.mem_rdata[7:0];
    endcase

    case (r_ld_funct3)
      F3_LB:  w_ld_value = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: w_ld_value = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        w_ld_value = {{(XLEN-16){w_half[15]}}, w_half};
        w_misalign = r_ld_addr_lo[0];
      end
      F3_LHU: begin
        w_ld_value = {{(XLEN-16){1'b0}}, w_half};
        w_misalign = r_ld_addr_lo[0];
      end
      F3_LW: begin
        w_ld_value = wb.mem_rdata;
        w_misalign = (r_ld_addr_lo != 2'd0);
      end
      default: w_bad_f3 = 1'b1;
    endcase
  end

  // Next state and next write-port values.
  always_comb begin
    w_next_state = r_state;
    w_wr_update  = 1'b0;
    w_wen_nxt    = 1'b0;
    w_rd_nxt     = r_rd;
    w_rdv_nxt    = r_rdv;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (wb.ex_is_load) begin
            w_next_state = WAIT_MEM;
          end else begin
            w_wr_update = 1'b1;
            w_wen_nxt   = (wb.ex_rd != 5'd0);
            w_rd_nxt    = wb.ex_rd;
            w_rdv_nxt   = wb.ex_result;
          end
        end
      end
      WAIT_MEM: begin
        if (w_ld_done) begin
          w_next_state = IDLE;
          // Faulting loads leave the write port untouched.
          if (!w_bad_f3 && !w_misalign) begin
            w_wr_update = 1'b1;
            w_wen_nxt   = (r_ld_rd != 5'd0);
            w_rd_nxt    = r_ld_rd;
            w_rdv_nxt   = w_ld_value;
          end
        end else if (w_tmo_hit) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_ld_rd        <= 5'd0;
      r_ld_funct3    <= 3'd0;
      r_ld_addr_lo   <= 2'd0;
      r_w_en         <= 1'b0;
      r_rd           <= 5'd0;
      r_rdv          <= '0;
      r_err_unexp    <= 1'b0;
      r_err_misalign <= 1'b0;
      r_err_funct3   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_next_state;
      r_w_en  <= w_wen_nxt;
      if (w_wr_update) begin
        r_rd  <= w_rd_nxt;
        r_rdv <= w_rdv_nxt;
      end
      if (w_accept_load) begin
        r_ld_rd      <= wb.ex_rd;
        r_ld_funct3  <= wb.ex_funct3;
        r_ld_addr_lo <= wb.ex_addr_lo;
      end
      // Sticky flags: a new event wins over a simultaneous clear.
      r_err_unexp    <= ((r_state == IDLE) && wb.mem_rvalid) ||
                        (r_err_unexp && !wb.err_clr);
      r_err_misalign <= (w_ld_done && !w_bad_f3 && w_misalign) ||
                        (r_err_misalign && !wb.err_clr);
      r_err_funct3   <= (w_ld_done && w_bad_f3) ||
                        (r_err_funct3 && !wb.err_clr);
    end
  end

  assign wb.ex_ready     = (r_state == IDLE);
  assign wb.pend_valid   = (r_state == WAIT_MEM);
  assign wb.pend_rd      = r_ld_rd;
  assign wb.w_en         = r_w_en;
  assign wb.rd           = r_rd;
  assign wb.rdv          = r_rdv;
  assign wb.err_unexp    = r_err_unexp;
  assign wb.err_misalign = r_err_misalign;
  assign wb.err_funct3   = r_err_funct3;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core; sits directly upstream of the register file and produces its write port (w_en, rd, rdv).
- Accepts retiring instructions from execute over a valid/ready handshake.
- ALU results: registered and written one cycle later.
- Loads: waits for memory read data, then aligns and sign/zero-extends it before writing.
- Exports the pending load destination so decode can stall on load-use hazards.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT_MEM before the load is aborted. Used only with LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept (combinational: state==IDLE)
- ex_rd  in  5  destination register
- ex_result  in  32  ALU result (ignored for loads)
- ex_is_load  in  1  instruction is a load
- ex_funct3  in  3  load width/sign
- ex_addr_lo  in  2  load byte address [1:0]
- mem_rvalid  in  1  memory read data valid, single-cycle pulse
- mem_rdata  in  32  aligned memory word
- w_en  out  1  register file write enable (registered)
- rd  out  5  register file write index (registered)
- rdv  out  32  register file write data (registered)
- pend_valid  out  1  load outstanding (state==WAIT_MEM)
- pend_rd  out  5  destination of the outstanding load
- err_clr  in  1  clears all sticky error flags
- err_unexp  out  1  sticky: mem_rvalid seen outside WAIT_MEM
- err_misalign  out  1  sticky: misaligned load
- err_funct3  out  1  sticky: illegal load funct3

Behaviour:
- Reset (async, rst_n=0): state=IDLE; w_en=0, rd=0, rdv=0; pend_rd=0; all error flags cleared; any captured load dropped.
- State machine has two states, IDLE and WAIT_MEM.
- Acceptance occurs when ex_valid && ex_ready.
- Non-load accepted at edge N:
  - w_en=(ex_rd!=0), rd=ex_rd, rdv=ex_result during cycle N+1.
  - State stays IDLE, so a back-to-back accept is allowed every cycle.
- Load accepted at edge N:
  - Capture ex_rd, ex_funct3, ex_addr_lo.
  - Go to WAIT_MEM; ex_ready=0 and pend_valid=1 from cycle N+1.
  - w_en=0 while waiting.
- In WAIT_MEM, with mem_rvalid=1 at edge M:
  - State returns to IDLE.
  - w_en/rd/rdv carry the extracted value during cycle M+1.
  - ex_ready=1 in cycle M+1.
- Extraction:
  - byte = mem_rdata[8*addr_lo +: 8]
  - half = mem_rdata[16*addr_lo[1] +: 16]
  - 000 LB: sign-extend byte
  - 100 LBU: zero-extend byte
  - 001 LH: sign-extend half
  - 101 LHU: zero-extend half
  - 010 LW: full word
- Misaligned load (LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0):
  - Detected at completion.
  - No write (w_en=0); err_misalign=1; state returns to IDLE.
- Illegal funct3 (011, 110, 111):
  - No write; err_funct3=1; state returns to IDLE.
- ex_rd==0 on any instruction: w_en stays 0; load handshake still completes normally.
- mem_rvalid while IDLE, including the same cycle a load is accepted: data ignored, err_unexp=1.
- ex_valid while in WAIT_MEM: not accepted; execute must hold its inputs.
- Error flags:
  - Sticky until err_clr=1 or reset.
  - If err_clr and a new error event occur in the same cycle, the set wins.
- w_en is a single-cycle pulse per write; with no acceptance or completion, w_en=0 next cycle (rd/rdv hold their last values).

Optional Feature:
- LOAD_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_MEM and increments each cycle without mem_rvalid.
  - When it reaches TIMEOUT_CYCLES, the stage returns to IDLE with no write and sets sticky err_timeout.
  - Adds output port err_timeout (1 bit); err_clr clears it.
  - A mem_rvalid arriving on the timeout edge completes the load normally; completion wins.
- LOAD_TIMEOUT_EN undefined: no counter, no err_timeout port; WAIT_MEM waits indefinitely.

Test Plan:
- ALU op with ex_rd=5, ex_result=0xDEADBEEF accepted at edge N -> w_en=1, rd=5, rdv=0xDEADBEEF in cycle N+1; w_en=0 in N+2.
- LB with rd=3, addr_lo=2, mem_rdata=0x12_80_34_56 after 3 wait cycles:
  - pend_valid=1 and pend_rd=3 while waiting; ex_ready=0.
  - Then w_en=1, rdv=0xFFFFFF80.
- LHU with addr_lo=2, mem_rdata=0x8001_0000 -> rdv=0x00008001. The same load as LH -> rdv=0xFFFF8001.
- Faults:
  - LW with addr_lo=1 -> no write, err_misalign=1.
  - mem_rvalid pulse while IDLE -> err_unexp=1.
  - err_clr -> both flags 0.
- Back-to-back ALU ops to rd=0 then rd=7 -> w_en=0 then w_en=1, rd=7.
- Reset mid-load:
  - rst_n low in WAIT_MEM -> w_en=0, pend_valid=0.
  - A later mem_rvalid -> err_unexp=1, no write.
- With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4:
  - Load with no response -> err_timeout=1 after 4 cycles, no write, ex_ready=1.
